multi_cycle_control_unit: RTL and testbench

MULTI_CYCLE_CONTROL_UNIT -- requirements
Module: multi_cycle_control_unit

---
 rtl/mips_ctrl_pkg.sv | 82 ++++++++
 rtl/multi_cycle_control_unit.sv | 200 ++++++++++++++++++++
 tb/tb_multi_cycle_control_unit.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg -- shared definitions for the multi-cycle MIPS control path.
//
// Holds the controller state encoding, the opcode constants, the datapath
// select codes (ALUOp, PCSrc, ALUSrcB) and the ALU-control decode function.
// The main controller and the ALU decoder both import this package, so the
// two sides always agree on what ALUOp=10 or PCSrc=01 means.
package mips_ctrl_pkg;

    // Controller states. The numeric values appear on the debug State port,
    // so they are pinned explicitly rather than left to the tool.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    // Primary opcode field values.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // ALU operation class handed to the ALU decoder.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // PC source mux select.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU B-operand mux select.
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // ALU control codes produced by the ALU decoder.
    localparam logic [2:0] ALUCTL_AND = 3'b000;
    localparam logic [2:0] ALUCTL_OR  = 3'b001;
    localparam logic [2:0] ALUCTL_ADD = 3'b010;
    localparam logic [2:0] ALUCTL_SUB = 3'b110;
    localparam logic [2:0] ALUCTL_SLT = 3'b111;

    // ALU decoder: maps the controller's ALUOp class plus the R-type funct
    // field onto the ALU control code. Unknown functs fall back to add so a
    // bad instruction never leaves the ALU in an undefined mode.
    function automatic logic [2:0] alu_decode(input logic [1:0] aluop,
                                              input logic [5:0] funct);
        logic [2:0] ctl;
        ctl = ALUCTL_ADD;
        case (aluop)
            ALUOP_ADD: ctl = ALUCTL_ADD;
            ALUOP_SUB: ctl = ALUCTL_SUB;
            default: begin
                case (funct)
                    6'b100000: ctl = ALUCTL_ADD;
                    6'b100010: ctl = ALUCTL_SUB;
                    6'b100100: ctl = ALUCTL_AND;
                    6'b100101: ctl = ALUCTL_OR;
                    6'b101010: ctl = ALUCTL_SLT;
                    default:   ctl = ALUCTL_ADD;
                endcase
            end
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/multi_cycle_control_unit.sv
// multi_cycle_control_unit -- main control FSM of a multi-cycle MIPS core.
//
// Sequences each instruction through FETCH/DECODE and its execution states,
// stalling on memory until Mem_Ready, and decodes the datapath controls from
// the current state (Moore) plus Mem_Ready for the write strobes.
//
// Ports:
//   CLK        in   clock, all state changes on the rising edge
//   RST        in   synchronous active-high reset; also zeroes outputs while high
//   Op_Code    in   instruction opcode, sampled in DECODE
//   Mem_Ready  in   memory handshake, access completes in the cycle it is high
//   IorD, IRWrite, PCWrite, Branch, Branch_Ne, MemWrite, MemtoReg, RegDst,
//   RegWrite, ALUSrcA                 out  1-bit datapath controls
//   ALUSrcB, ALUOp, PCSrc             out  2-bit selects / ALU class
//   Illegal_Op out   one-cycle pulse in DECODE on an undecodable opcode
//   State      out   current state encoding (debug)
module multi_cycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int OP_WIDTH = 6,
    parameter bit BNE_EN   = 1'b1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [OP_WIDTH-1:0] Op_Code,
    input  logic                Mem_Ready,
    output logic                IorD,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic                Branch,
    output logic                Branch_Ne,
    output logic                MemWrite,
    output logic                MemtoReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ALUOp,
    output logic [1:0]          PCSrc,
    output logic                Illegal_Op,
    output logic [3:0]          State
);

    // Opcode constants resized to the configured field width.
    localparam logic [OP_WIDTH-1:0] OPW_RTYPE = OP_WIDTH'(OP_RTYPE);
    localparam logic [OP_WIDTH-1:0] OPW_J     = OP_WIDTH'(OP_J);
    localparam logic [OP_WIDTH-1:0] OPW_BEQ   = OP_WIDTH'(OP_BEQ);
    localparam logic [OP_WIDTH-1:0] OPW_BNE   = OP_WIDTH'(OP_BNE);
    localparam logic [OP_WIDTH-1:0] OPW_ADDI  = OP_WIDTH'(OP_ADDI);
    localparam logic [OP_WIDTH-1:0] OPW_LW    = OP_WIDTH'(OP_LW);
    localparam logic [OP_WIDTH-1:0] OPW_SW    = OP_WIDTH'(OP_SW);

    state_t              state_reg;
    state_t              state_next;
    logic [OP_WIDTH-1:0] op_code_reg;

    // BNE is only legal when the build enables it.
    function automatic logic op_is_legal(input logic [OP_WIDTH-1:0] op);
        return (op == OPW_LW)    || (op == OPW_SW)   ||
               (op == OPW_RTYPE) || (op == OPW_BEQ)  ||
               (op == OPW_ADDI)  || (op == OPW_J)    ||
               (BNE_EN && (op == OPW_BNE));
    endfunction

    // State register and opcode latch. The opcode is captured on the edge
    // leaving DECODE so MEMADR and BRANCH see the instruction being executed
    // even if Op_Code changes afterwards.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= S_FETCH;
            op_code_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_DECODE) begin
                op_code_reg <= Op_Code;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH: begin
                if (Mem_Ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                if ((Op_Code == OPW_LW) || (Op_Code == OPW_SW)) begin
                    state_next = S_MEMADR;
                end else if (Op_Code == OPW_RTYPE) begin
                    state_next = S_EXECUTE;
                end else if ((Op_Code == OPW_BEQ) ||
                             (BNE_EN && (Op_Code == OPW_BNE))) begin
                    state_next = S_BRANCH;
                end else if (Op_Code == OPW_ADDI) begin
                    state_next = S_ADDIEXEC;
                end else if (Op_Code == OPW_J) begin
                    state_next = S_JUMP;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_MEMADR: begin
                // Only lw/sw reach here; anything else would be a corrupted
                // latch, so fall back to FETCH rather than stall.
                if (op_code_reg == OPW_LW)      state_next = S_MEMRD;
                else if (op_code_reg == OPW_SW) state_next = S_MEMWR;
                else                            state_next = S_FETCH;
            end
            S_MEMRD: begin
                if (Mem_Ready) state_next = S_MEMWB;
            end
            S_MEMWR: begin
                if (Mem_Ready) state_next = S_FETCH;
            end
            S_EXECUTE:  state_next = S_ALUWB;
            S_ADDIEXEC: state_next = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_next = S_FETCH;
            default:    state_next = S_FETCH;
        endcase
    end

    // Output decode. Reset takes effect on the next edge, so outputs are
    // gated here as well to keep everything quiet while RST is high, even if
    // the registered state is mid-instruction.
    always_comb begin
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        Branch_Ne  = 1'b0;
        MemWrite   = 1'b0;
        MemtoReg   = 1'b0;
        RegDst     = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        ALUOp      = ALUOP_ADD;
        PCSrc      = PCSRC_ALU;
        Illegal_Op = 1'b0;
        State      = S_FETCH;
        if (!RST) begin
            State = state_reg;
            case (state_reg)
                S_FETCH: begin
                    // PC+4 is computed every fetch cycle, but the IR and PC
                    // only load once memory delivers the word.
                    ALUSrcB = SRCB_FOUR;
                    IRWrite = Mem_Ready;
                    PCWrite = Mem_Ready;
                end
                S_DECODE: begin
                    // Speculative branch target: PC + (imm << 2).
                    ALUSrcB    = SRCB_IMM_SH;
                    Illegal_Op = !op_is_legal(Op_Code);
                end
                S_MEMADR, S_ADDIEXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEMRD: begin
                    IorD = 1'b1;
                end
                S_MEMWR: begin
                    IorD     = 1'b1;
                    MemWrite = Mem_Ready;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_EXECUTE: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                S_ADDIWB: begin
                    RegWrite = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA   = 1'b1;
                    ALUOp     = ALUOP_SUB;
                    PCSrc     = PCSRC_ALUOUT;
                    Branch    = (op_code_reg == OPW_BEQ);
                    Branch_Ne = BNE_EN && (op_code_reg == OPW_BNE);
                end
                S_JUMP: begin
                    PCSrc   = PCSRC_JUMP;
                    PCWrite = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Bench for multi_cycle_control_unit. Two instances share the stimulus:
// dut_a with BNE enabled (default) and dut_b with BNE disabled. The stimulus
// process drives one cycle at a time and queues the hand-computed expected
// response; the monitor pops and compares on the falling edge.
module tb_multi_cycle_control_unit;

    // State encodings as seen on the debug port.
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMRD    = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWR    = 4'd5;
    localparam logic [3:0] S_EXECUTE  = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_ADDIEXEC = 4'd9;
    localparam logic [3:0] S_ADDIWB   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;

    // Control vector layout:
    // [15]IorD [14]IRWrite [13]PCWrite [12]Branch [11]Branch_Ne [10]MemWrite
    // [9]MemtoReg [8]RegDst [7]RegWrite [6]ALUSrcA [5:4]ALUSrcB [3:2]ALUOp [1:0]PCSrc
    localparam logic [15:0] C_ZERO        = 16'h0000;
    localparam logic [15:0] C_FETCH_STALL = 16'h0010;
    localparam logic [15:0] C_FETCH_GO    = 16'h6010;
    localparam logic [15:0] C_DECODE      = 16'h0030;
    localparam logic [15:0] C_MEMADR      = 16'h0060;
    localparam logic [15:0] C_MEMRD       = 16'h8000;
    localparam logic [15:0] C_MEMWB       = 16'h0280;
    localparam logic [15:0] C_MEMWR_STALL = 16'h8000;
    localparam logic [15:0] C_MEMWR_GO    = 16'h8400;
    localparam logic [15:0] C_EXEC        = 16'h0048;
    localparam logic [15:0] C_ALUWB       = 16'h0180;
    localparam logic [15:0] C_ADDIWB      = 16'h0080;
    localparam logic [15:0] C_BEQ         = 16'h1045;
    localparam logic [15:0] C_BNE         = 16'h0845;
    localparam logic [15:0] C_JUMP        = 16'h2002;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;

    typedef struct {
        string       name;
        logic [3:0]  st;
        logic [15:0] ctl;
        logic        ill;
        logic        chk_b;
        logic [3:0]  st_b;
        logic        ill_b;
    } exp_t;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic [5:0] Op_Code = 6'b0;
    logic       Mem_Ready = 1'b0;

    logic       iord_a, irw_a, pcw_a, br_a, bne_a, mw_a, m2r_a, rd_a, rw_a, asa_a, ill_a;
    logic [1:0] asb_a, aop_a, pcs_a;
    logic [3:0] st_a;
    logic       iord_b, irw_b, pcw_b, br_b, bne_b, mw_b, m2r_b, rd_b, rw_b, asa_b, ill_b;
    logic [1:0] asb_b, aop_b, pcs_b;
    logic [3:0] st_b;

    exp_t exp_q[$];
    int   assert_count = 0;
    int   fail_count   = 0;
    bit   stim_done    = 1'b0;

    always #5 clk = ~clk;

    multi_cycle_control_unit dut_a (
        .CLK(clk), .RST(RST), .Op_Code(Op_Code), .Mem_Ready(Mem_Ready),
        .IorD(iord_a), .IRWrite(irw_a), .PCWrite(pcw_a), .Branch(br_a),
        .Branch_Ne(bne_a), .MemWrite(mw_a), .MemtoReg(m2r_a), .RegDst(rd_a),
        .RegWrite(rw_a), .ALUSrcA(asa_a), .ALUSrcB(asb_a), .ALUOp(aop_a),
        .PCSrc(pcs_a), .Illegal_Op(ill_a), .State(st_a)
    );

    multi_cycle_control_unit #(.OP_WIDTH(6), .BNE_EN(1'b0)) dut_b (
        .CLK(clk), .RST(RST), .Op_Code(Op_Code), .Mem_Ready(Mem_Ready),
        .IorD(iord_b), .IRWrite(irw_b), .PCWrite(pcw_b), .Branch(br_b),
        .Branch_Ne(bne_b), .MemWrite(mw_b), .MemtoReg(m2r_b), .RegDst(rd_b),
        .RegWrite(rw_b), .ALUSrcA(asa_b), .ALUSrcB(asb_b), .ALUOp(aop_b),
        .PCSrc(pcs_b), .Illegal_Op(ill_b), .State(st_b)
    );

    // One cycle of stimulus: inputs for this cycle plus the expected outputs
    // of that same cycle.
    task automatic step(input string name, input logic rst, input logic [5:0] op,
                        input logic mr, input logic [3:0] st, input logic [15:0] ctl,
                        input logic ill, input logic chk_b = 1'b0,
                        input logic [3:0] stb = 4'd0, input logic illb = 1'b0);
        exp_t e;
        @(posedge clk);
        #1;
        RST       = rst;
        Op_Code   = op;
        Mem_Ready = mr;
        e.name  = name;
        e.st    = st;
        e.ctl   = ctl;
        e.ill   = ill;
        e.chk_b = chk_b;
        e.st_b  = stb;
        e.ill_b = illb;
        exp_q.push_back(e);
    endtask

    // Monitor / scoreboard.
    initial begin
        exp_t        e;
        logic [15:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {iord_a, irw_a, pcw_a, br_a, bne_a, mw_a, m2r_a, rd_a,
                       rw_a, asa_a, asb_a, aop_a, pcs_a};
                $display("%-12s state=%0d ctl=%h illegal=%b", e.name, st_a, act, ill_a);
                assert_count++;
                if (st_a !== e.st) begin
                    fail_count++;
                    $display("FAIL %s state: got %0d want %0d", e.name, st_a, e.st);
                end
                assert_count++;
                if (act !== e.ctl) begin
                    fail_count++;
                    $display("FAIL %s ctl: got %h want %h", e.name, act, e.ctl);
                end
                assert_count++;
                if (ill_a !== e.ill) begin
                    fail_count++;
                    $display("FAIL %s illegal: got %b want %b", e.name, ill_a, e.ill);
                end
                if (e.chk_b) begin
                    assert_count++;
                    if (st_b !== e.st_b) begin
                        fail_count++;
                        $display("FAIL %s state_nobne: got %0d want %0d", e.name, st_b, e.st_b);
                    end
                    assert_count++;
                    if (ill_b !== e.ill_b) begin
                        fail_count++;
                        $display("FAIL %s illegal_nobne: got %b want %b", e.name, ill_b, e.ill_b);
                    end
                end
            end
        end
    end

    // Stimulus.
    initial begin
        // lw after a 2-cycle reset: 5 cycles, RegWrite/MemtoReg only in MEMWB
        step("rst0",      1, LW, 1, S_FETCH,   C_ZERO,     0, 1, S_FETCH, 0);
        step("rst1",      1, LW, 1, S_FETCH,   C_ZERO,     0);
        step("lw_fetch",  0, LW, 1, S_FETCH,   C_FETCH_GO, 0);
        step("lw_decode", 0, LW, 1, S_DECODE,  C_DECODE,   0);
        step("lw_memadr", 0, LW, 1, S_MEMADR,  C_MEMADR,   0);
        step("lw_memrd",  0, LW, 1, S_MEMRD,   C_MEMRD,    0);
        step("lw_memwb",  0, LW, 1, S_MEMWB,   C_MEMWB,    0);
        // sw with a fetch stall and a 3-cycle write stall
        step("sw_fstall", 0, SW, 0, S_FETCH,   C_FETCH_STALL, 0);
        step("sw_fetch",  0, SW, 1, S_FETCH,   C_FETCH_GO,    0);
        step("sw_decode", 0, SW, 1, S_DECODE,  C_DECODE,      0);
        step("sw_memadr", 0, SW, 0, S_MEMADR,  C_MEMADR,      0);
        for (int i = 0; i < 3; i++)
            step("sw_wstall", 0, SW, 0, S_MEMWR, C_MEMWR_STALL, 0);
        step("sw_memwr",  0, SW, 1, S_MEMWR,   C_MEMWR_GO,    0);
        // R-type
        step("rt_fetch",  0, RT, 1, S_FETCH,   C_FETCH_GO, 0);
        step("rt_decode", 0, RT, 1, S_DECODE,  C_DECODE,   0);
        step("rt_exec",   0, RT, 1, S_EXECUTE, C_EXEC,     0);
        step("rt_aluwb",  0, RT, 1, S_ALUWB,   C_ALUWB,    0);
        // addi
        step("ad_fetch",  0, ADDI, 1, S_FETCH,    C_FETCH_GO, 0);
        step("ad_decode", 0, ADDI, 1, S_DECODE,   C_DECODE,   0);
        step("ad_exec",   0, ADDI, 1, S_ADDIEXEC, C_MEMADR,   0);
        step("ad_wb",     0, ADDI, 1, S_ADDIWB,   C_ADDIWB,   0);
        // beq
        step("bq_fetch",  0, BEQ, 1, S_FETCH,  C_FETCH_GO, 0);
        step("bq_decode", 0, BEQ, 1, S_DECODE, C_DECODE,   0);
        step("bq_branch", 0, BEQ, 1, S_BRANCH, C_BEQ,      0, 1, S_BRANCH, 0);
        // invalid opcode: pulse in DECODE only, straight back to FETCH
        step("il_fetch",  0, BAD, 1, S_FETCH,  C_FETCH_GO, 0);
        step("il_decode", 0, BAD, 1, S_DECODE, C_DECODE,   1, 1, S_DECODE, 1);
        step("il_back",   0, BAD, 0, S_FETCH,  C_FETCH_STALL, 0, 1, S_FETCH, 0);
        // reset during EXECUTE: outputs quiet, FETCH after the edge, no ALUWB
        step("rx_fetch",  0, RT, 1, S_FETCH,   C_FETCH_GO, 0);
        step("rx_decode", 0, RT, 1, S_DECODE,  C_DECODE,   0);
        step("rx_rst",    1, RT, 1, S_FETCH,   C_ZERO,     0);
        step("rx_after",  0, RT, 0, S_FETCH,   C_FETCH_STALL, 0);
        step("rx_after2", 0, RT, 0, S_FETCH,   C_FETCH_STALL, 0);
        // jump
        step("j_fetch",   0, JMP, 1, S_FETCH,  C_FETCH_GO, 0);
        step("j_decode",  0, JMP, 1, S_DECODE, C_DECODE,   0);
        step("j_jump",    0, JMP, 1, S_JUMP,   C_JUMP,     0);
        step("j_back",    0, JMP, 0, S_FETCH,  C_FETCH_STALL, 0);
        // bne: dut_a branches, dut_b (BNE disabled) flags it and refetches.
        // The two diverge here, so a reset cycle closes the test; during it
        // dut_b sits in DECODE with 000101 but must stay quiet.
        step("bn_fetch",  0, BNE, 1, S_FETCH,  C_FETCH_GO, 0, 1, S_FETCH,  0);
        step("bn_decode", 0, BNE, 1, S_DECODE, C_DECODE,   0, 1, S_DECODE, 1);
        step("bn_branch", 0, BNE, 1, S_BRANCH, C_BNE,      0, 1, S_FETCH,  0);
        step("bn_rst",    1, BNE, 1, S_FETCH,  C_ZERO,     0, 1, S_FETCH,  0);
        step("bn_after",  0, BNE, 0, S_FETCH,  C_FETCH_STALL, 0, 1, S_FETCH, 0);
        repeat (3) @(posedge clk);
        assert_count++;
        if (exp_q.size() != 0) begin
            fail_count++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        stim_done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

    initial begin
        #100000;
        if (!stim_done) begin
            $display("FAIL timeout: got no completion want completion");
            $fatal(1, "timeout");
        end
    end

endmodule
